ram_port_arbiter: RTL and testbench

Shares one single-port, 1-cycle-read-latency memory port between the three engine streams: pixel read, weights read and output write. It sits between the cgra4ml engine's memory-side request ports and the AXI-to-RAM bridge. It arbitrates round-robin, with a bounded burst lock so that sequential streams keep locality. It routes returned read data back to the requester that owns it.

---
 rtl/ram_arb_pkg.sv | 50 +++++
 rtl/ram_port_arbiter_rr_pick3.sv | 26 ++
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the three-stream RAM port arbiter.
// Stream index order is pixel=0, weights=1, output=2, which is also the round-robin order.
package ram_arb_pkg;

  localparam int N_REQ = 3;

  localparam logic [1:0] IDX_PIXEL   = 2'd0;
  localparam logic [1:0] IDX_WEIGHTS = 2'd1;
  localparam logic [1:0] IDX_OUTPUT  = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_PIXEL   = 2'd1,
    OWN_WEIGHTS = 2'd2,
    OWN_OUTPUT  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_PIXEL   = 2'd1,
    TAG_WEIGHTS = 2'd2
  } tag_e;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == IDX_OUTPUT) ? IDX_PIXEL : idx + 2'd1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot_of(input owner_e own);
    case (own)
      OWN_PIXEL:   return 3'b001;
      OWN_WEIGHTS: return 3'b010;
      OWN_OUTPUT:  return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  function automatic owner_e owner_of(input logic [N_REQ-1:0] oh);
    if (oh[0]) return OWN_PIXEL;
    if (oh[1]) return OWN_WEIGHTS;
    if (oh[2]) return OWN_OUTPUT;
    return OWN_NONE;
  endfunction

  function automatic logic [1:0] idx_of(input logic [N_REQ-1:0] oh);
    if (oh[1]) return IDX_WEIGHTS;
    if (oh[2]) return IDX_OUTPUT;
    return IDX_PIXEL;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters.
// The search begins at start_i and wraps; the first requester found wins.
module rr_pick3
  import ram_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       start_i,
  output logic [N_REQ-1:0] win_o,
  output logic             valid_o
);

  always_comb begin : pick
    logic [1:0] idx;
    win_o   = '0;
    valid_o = 1'b0;
    idx     = start_i;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one 1-cycle-latency RAM port between pixel/weights reads and output writes.
// Define RAM_ARB_WR_PRIORITY_EN to let output writes pre-empt the reads in any cycle they request.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AXI_WIDTH = 128,
  parameter int ADDR_W    = 28,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rd_pixel_req,
  input  logic [ADDR_W-1:0]      i_raddr_pixel,
  output logic                   o_rd_pixel_gnt,
  output logic                   o_rvalid_pixel,
  output logic [AXI_WIDTH-1:0]   o_rdata_pixel,
  input  logic                   i_rd_weights_req,
  input  logic [ADDR_W-1:0]      i_raddr_weights,
  output logic                   o_rd_weights_gnt,
  output logic                   o_rvalid_weights,
  output logic [AXI_WIDTH-1:0]   o_rdata_weights,
  input  logic                   i_we_output_req,
  input  logic [ADDR_W-1:0]      i_waddr_output,
  input  logic [AXI_WIDTH-1:0]   i_wdata_output,
  input  logic [AXI_WIDTH/8-1:0] i_wstrb_output,
  output logic                   o_we_output_gnt,
  output logic                   o_rd,
  output logic [ADDR_W-1:0]      o_raddr,
  input  logic [AXI_WIDTH-1:0]   i_rdata,
  output logic                   o_we,
  output logic [ADDR_W-1:0]      o_waddr,
  output logic [AXI_WIDTH-1:0]   o_wdata,
  output logic [AXI_WIDTH/8-1:0] o_wstrb
);

  localparam int              BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]   BEAT_LAST = BW'(MAX_BURST - 1);

  owner_e           owner_q, owner_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [1:0]       last_q, last_d;
  tag_e             tag_q, tag_d;

  logic [N_REQ-1:0] req, own_oh, pick_req, pick_win, win;
  logic             pick_valid, own_req, expired, solo;

  assign req     = {i_we_output_req, i_rd_weights_req, i_rd_pixel_req};
  assign own_oh  = onehot_of(owner_q);
  assign own_req = |(req & own_oh);
  assign expired = (beat_q == BEAT_LAST);

  // The owner is always excluded from the search: it only matters when its lock ran out.
`ifdef RAM_ARB_WR_PRIORITY_EN
  assign pick_req = req & ~own_oh & 3'b011;
`else
  assign pick_req = req & ~own_oh;
`endif

  rr_pick3 u_pick (
    .req_i   (pick_req),
    .start_i (rr_next(last_q)),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_comb begin
    win  = '0;
    solo = 1'b0;
    if (!rst) begin
      if (own_req && !expired) begin
        win = own_oh;
      end else if (pick_valid) begin
        win = pick_win;
      end else if (own_req) begin
        win  = own_oh;
        solo = 1'b1;
      end
`ifdef RAM_ARB_WR_PRIORITY_EN
      if (i_we_output_req) begin
        win  = 3'b100;
        solo = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    owner_d = owner_q;
    beat_d  = beat_q;
    last_d  = last_q;
    if (win == '0) begin
      owner_d = OWN_NONE;
      beat_d  = '0;
    end else if (win == own_oh) begin
      // Saturating restart also covers a priority write held past its lock.
      beat_d = (solo || expired) ? '0 : beat_q + 1'b1;
    end else begin
      owner_d = owner_of(win);
      beat_d  = '0;
      last_d  = idx_of(win);
    end
    tag_d = win[0] ? TAG_PIXEL : (win[1] ? TAG_WEIGHTS : TAG_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      beat_q  <= '0;
      last_q  <= IDX_OUTPUT;
      tag_q   <= TAG_NONE;
    end else begin
      owner_q <= owner_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  assign o_rd_pixel_gnt   = win[0];
  assign o_rd_weights_gnt = win[1];
  assign o_we_output_gnt  = win[2];

  assign o_rd    = win[0] | win[1];
  assign o_raddr = win[0] ? i_raddr_pixel : (win[1] ? i_raddr_weights : '0);
  assign o_we    = win[2];
  assign o_waddr = win[2] ? i_waddr_output : '0;
  assign o_wdata = win[2] ? i_wdata_output : '0;
  assign o_wstrb = win[2] ? i_wstrb_output : '0;

  assign o_rvalid_pixel   = !rst && (tag_q == TAG_PIXEL);
  assign o_rvalid_weights = !rst && (tag_q == TAG_WEIGHTS);
  assign o_rdata_pixel    = i_rdata;
  assign o_rdata_weights  = i_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: requester drivers push expected responses, a negedge monitor pops and checks.
// Honours RAM_ARB_WR_PRIORITY_EN for the write-preemption scenario.
module tb_ram_port_arbiter;
  localparam int AW  = 128;
  localparam int ADW = 28;
  localparam int SW  = 16;
  localparam int MB  = 4;

  localparam logic [1:0] C_P = 2'd1;
  localparam logic [1:0] C_W = 2'd2;
  localparam logic [1:0] C_O = 2'd3;

  typedef struct {
    logic [ADW-1:0] addr;
    logic [AW-1:0]  data;
    logic [SW-1:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic           i_rd_pixel_req, i_rd_weights_req, i_we_output_req;
  logic [ADW-1:0] i_raddr_pixel, i_raddr_weights, i_waddr_output;
  logic [AW-1:0]  i_wdata_output, i_rdata;
  logic [SW-1:0]  i_wstrb_output;
  logic           o_rd_pixel_gnt, o_rd_weights_gnt, o_we_output_gnt;
  logic           o_rvalid_pixel, o_rvalid_weights, o_rd, o_we;
  logic [AW-1:0]  o_rdata_pixel, o_rdata_weights, o_wdata;
  logic [ADW-1:0] o_raddr, o_waddr;
  logic [SW-1:0]  o_wstrb;

  ram_port_arbiter #(.AXI_WIDTH(AW), .ADDR_W(ADW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .i_rd_pixel_req(i_rd_pixel_req), .i_raddr_pixel(i_raddr_pixel),
    .o_rd_pixel_gnt(o_rd_pixel_gnt), .o_rvalid_pixel(o_rvalid_pixel), .o_rdata_pixel(o_rdata_pixel),
    .i_rd_weights_req(i_rd_weights_req), .i_raddr_weights(i_raddr_weights),
    .o_rd_weights_gnt(o_rd_weights_gnt), .o_rvalid_weights(o_rvalid_weights), .o_rdata_weights(o_rdata_weights),
    .i_we_output_req(i_we_output_req), .i_waddr_output(i_waddr_output),
    .i_wdata_output(i_wdata_output), .i_wstrb_output(i_wstrb_output), .o_we_output_gnt(o_we_output_gnt),
    .o_rd(o_rd), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wstrb(o_wstrb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADW-1:0] pix_q[$], wgt_q[$];
  wr_t            out_q[$];
  logic [AW-1:0]  exp_pix[$], exp_wgt[$];
  logic [1:0]     exp_gnt[$];

  function automatic logic [AW-1:0] rd_pattern(input logic [ADW-1:0] a);
    return {4{32'hC0DE_0000 ^ {4'h0, a}}};
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: 1-cycle read latency, content is a fixed function of address.
  logic [AW-1:0] rdata_r = '0;
  always @(posedge clk) if (o_rd) rdata_r <= rd_pattern(o_raddr);
  assign i_rdata = rdata_r;

  // Requester drivers: hold req/address until a sampled req&&gnt, then move to the next entry.
  logic tp, tw, to;
  initial begin
    i_rd_pixel_req = 0; i_rd_weights_req = 0; i_we_output_req = 0;
    i_raddr_pixel = '0; i_raddr_weights = '0; i_waddr_output = '0;
    i_wdata_output = '0; i_wstrb_output = '0;
    forever begin
      @(negedge clk);
      tp = i_rd_pixel_req && o_rd_pixel_gnt;
      tw = i_rd_weights_req && o_rd_weights_gnt;
      to = i_we_output_req && o_we_output_gnt;
      @(posedge clk); #2;
      if (tp && pix_q.size() > 0) begin exp_pix.push_back(rd_pattern(pix_q[0])); pix_q.delete(0); end
      if (tw && wgt_q.size() > 0) begin exp_wgt.push_back(rd_pattern(wgt_q[0])); wgt_q.delete(0); end
      if (to && out_q.size() > 0) out_q.delete(0);
      i_rd_pixel_req   = pix_q.size() > 0;
      i_raddr_pixel    = (pix_q.size() > 0) ? pix_q[0] : '0;
      i_rd_weights_req = wgt_q.size() > 0;
      i_raddr_weights  = (wgt_q.size() > 0) ? wgt_q[0] : '0;
      i_we_output_req  = out_q.size() > 0;
      i_waddr_output   = (out_q.size() > 0) ? out_q[0].addr : '0;
      i_wdata_output   = (out_q.size() > 0) ? out_q[0].data : '0;
      i_wstrb_output   = (out_q.size() > 0) ? out_q[0].strb : '0;
    end
  end

  // Monitor
  logic       pp = 0, pw = 0;
  bit         started = 0;
  logic [1:0] code;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_quiet", AW'({o_rd_pixel_gnt, o_rd_weights_gnt, o_we_output_gnt, o_rd, o_we,
                              o_rvalid_pixel, o_rvalid_weights}), '0);
        if (pp && exp_pix.size() > 0) exp_pix.delete(0);
        if (pw && exp_wgt.size() > 0) exp_wgt.delete(0);
        started = 0;
      end else begin
        chk("rvalid_pixel_lat", AW'(o_rvalid_pixel), AW'(pp));
        chk("rvalid_weights_lat", AW'(o_rvalid_weights), AW'(pw));
        if (o_rvalid_pixel) begin
          if (exp_pix.size() == 0) chk("pixel_unexpected", 1, 0);
          else begin chk("rdata_pixel", o_rdata_pixel, exp_pix[0]); exp_pix.delete(0); end
        end
        if (o_rvalid_weights) begin
          if (exp_wgt.size() == 0) chk("weights_unexpected", 1, 0);
          else begin chk("rdata_weights", o_rdata_weights, exp_wgt[0]); exp_wgt.delete(0); end
        end
        chk("rd_we_exclusive", AW'(o_rd && o_we), 0);
        chk("gnt_onehot", AW'($countones({o_rd_pixel_gnt, o_rd_weights_gnt, o_we_output_gnt}) > 1), 0);
        chk("rd_follows_gnt", AW'(o_rd), AW'(o_rd_pixel_gnt || o_rd_weights_gnt));
        chk("we_follows_gnt", AW'(o_we), AW'(o_we_output_gnt));
        if (o_rd_pixel_gnt) chk("raddr_pixel", AW'(o_raddr), AW'(i_raddr_pixel));
        if (o_rd_weights_gnt) chk("raddr_weights", AW'(o_raddr), AW'(i_raddr_weights));
        if (o_we_output_gnt) begin
          if (out_q.size() == 0) chk("write_unexpected", 1, 0);
          else begin
            chk("waddr", AW'(o_waddr), AW'(out_q[0].addr));
            chk("wdata", o_wdata, out_q[0].data);
            chk("wstrb", AW'(o_wstrb), AW'(out_q[0].strb));
          end
        end
        if (!o_rd) chk("raddr_idle_zero", AW'(o_raddr), 0);
        if (!o_we) chk("wcmd_idle_zero", AW'({o_waddr, o_wstrb}) | o_wdata, 0);
        code = o_rd_pixel_gnt ? C_P : (o_rd_weights_gnt ? C_W : (o_we_output_gnt ? C_O : 2'd0));
        if (exp_gnt.size() > 0) begin
          if (code != 2'd0) begin
            chk("gnt_seq", AW'(code), AW'(exp_gnt[0]));
            exp_gnt.delete(0);
            started = (exp_gnt.size() > 0);
          end else if (started) begin
            chk("gnt_gap", AW'(code), AW'(exp_gnt[0]));
            exp_gnt.delete(0);
            started = (exp_gnt.size() > 0);
          end
        end
      end
      pp = o_rd_pixel_gnt;
      pw = o_rd_weights_gnt;
    end
  end

  task automatic push_seq(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) exp_gnt.push_back(c);
  endtask

  task automatic push_out(input int k);
    wr_t w;
    w.addr = ADW'(16 + k);
    w.data = {4{32'hBEEF_0000 | 32'(k)}};
    w.strb = 16'hF0F0 ^ 16'(k);
    out_q.push_back(w);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (pix_q.size() == 0 && wgt_q.size() == 0 && out_q.size() == 0 && exp_gnt.size() == 0) break;
      @(posedge clk); #1;
    end
    if (i >= 300) chk({name, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1; rst = 0;

    // Pixel only, addresses 0..7
    for (int a = 0; a < 8; a++) pix_q.push_back(ADW'(a));
    push_seq(C_P, 8);
    wait_done("pixel_only");

    // Full contention from reset: P x4, W x4, O x4, repeated
    do_reset();
    for (int a = 0; a < 8; a++) begin
      pix_q.push_back(ADW'(a)); wgt_q.push_back(ADW'(8 + a)); push_out(a);
    end
    repeat (2) begin push_seq(C_P, 4); push_seq(C_W, 4); push_seq(C_O, 4); end
    wait_done("contention");

    // Pixel drops at beat 2 while weights waits: weights follows with no bubble
    do_reset();
    for (int a = 0; a < 3; a++) pix_q.push_back(ADW'(a));
    wgt_q.push_back(ADW'(5)); wgt_q.push_back(ADW'(6));
    push_seq(C_P, 3); push_seq(C_W, 2);
    wait_done("lock_drop");

    // Lone weights requester: ten back-to-back grants
    for (int a = 0; a < 10; a++) wgt_q.push_back(ADW'(a));
    push_seq(C_W, 10);
    wait_done("weights_only");

    // Reset one cycle after a pixel grant drops the pending return
    pix_q.push_back(ADW'(5)); pix_q.push_back(ADW'(6));
    cnt = 0;
    for (int i = 0; i < 20 && cnt == 0; i++) begin
      @(negedge clk);
      if (o_rd_pixel_gnt) cnt = 1;
    end
    if (cnt == 0) chk("reset_mid_timeout", 1, 0);
    @(posedge clk); #1; rst = 1;
    wgt_q.push_back(ADW'(3)); push_out(9);
    repeat (2) @(posedge clk);
    #1; rst = 0;
    push_seq(C_P, 1); push_seq(C_W, 1); push_seq(C_O, 1);
    wait_done("reset_mid");

    // Write raised in the middle of a pixel burst
    do_reset();
    for (int a = 0; a < 8; a++) pix_q.push_back(ADW'(a));
`ifdef RAM_ARB_WR_PRIORITY_EN
    push_seq(C_P, 2); push_seq(C_O, 2); push_seq(C_P, 6);
`else
    push_seq(C_P, 4); push_seq(C_O, 2); push_seq(C_P, 4);
`endif
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      if (o_rd_pixel_gnt) cnt++;
    end
    if (cnt < 2) chk("write_mid_timeout", 1, 0);
    @(posedge clk); #1;
    push_out(1); push_out(2);
    wait_done("write_mid");

    chk("exp_gnt_drained", AW'(exp_gnt.size()), 0);
    chk("exp_pix_drained", AW'(exp_pix.size()), 0);
    chk("exp_wgt_drained", AW'(exp_wgt.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
